gc_poll_scheduler: RTL and testbench
====================================

Name: gc_poll_scheduler

Overview:
- Sequences the GameCube controller link: probes for a pad, then issues periodic poll commands with the rumble bit.
- Validates responses and publishes the latest button/stick frame.
- Sits above the 1 µs-tick bit transmitter (`gc_tx`) and bit receiver (`gc_rx`) on the same open-drain line.
- Owns the only right to start transmissions, so `tx` and `rx` never overlap.

Parameters:
- POLL_PERIOD, 1666666, clk100mhz cycles between poll starts (16.67 ms).
- RESP_TIMEOUT, 50000, cycles allowed from `tx_done` to `rx_valid` (500 µs).
- MAX_RETRY, 3, consecutive failed transactions before the pad is declared disconnected.

Ports:
- clk100mhz  in  1  system clock, 100 MHz
- reset  in  1  synchronous, active-high reset
- enable  in  1  1 = run polling; 0 = finish current transaction, then idle
- rumble  in  1  rumble bit sampled when each poll command is built
- tx_start  out  1  one-cycle pulse: transmitter sends `tx_cmd`
- tx_cmd  out  24  command bits, MSB first, left-aligned
- tx_len  out  5  number of command bits (8 or 24)
- tx_busy  in  1  transmitter active
- tx_done  in  1  one-cycle pulse after stop bit sent
- rx_arm  out  1  receiver enabled
- rx_valid  in  1  one-cycle pulse: response captured
- rx_data  in  64  response bits, left-aligned (first bit at [63])
- rx_count  in  7  number of bits captured
- rx_error  in  1  bit-timing error, valid with `rx_valid`
- pad_data  out  64  last valid poll response
- pad_valid  out  1  one-cycle pulse when `pad_data` updates
- connected  out  1  pad present
- err_count  out  8  failed transactions, saturating at 255

Behaviour:
- **Reset values:** all outputs 0; state = IDLE; retry counter 0; period counter 0. Reset mid-transaction aborts immediately; no `tx_start` or `rx_arm` is asserted in the following cycle.
- **States:** IDLE, PROBE_TX, POLL_WAIT, POLL_TX, WAIT_TXDONE, WAIT_RX, BACKOFF.
- **IDLE:**
  - `enable`=1 → PROBE_TX if `connected`=0, else POLL_WAIT.
- **PROBE_TX / POLL_TX:**
  - Wait for `tx_busy`=0, then pulse `tx_start` for one cycle and go to WAIT_TXDONE.
  - Probe: `tx_cmd`=0x000000, `tx_len`=8.
  - Poll: `tx_cmd`={0x4003, 7'b0, rumble}, `tx_len`=24.
  - The period counter reloads to 0 on the poll `tx_start` cycle.
- **Command stability:** `tx_cmd`/`tx_len` are registered on the `tx_start` cycle and held until the next `tx_start`.
- **WAIT_TXDONE:**
  - On `tx_done` → WAIT_RX.
  - `rx_arm`=1 from the cycle after `tx_done` until the cycle after the response resolves.
  - The timeout counter clears on entry to WAIT_RX.
- **WAIT_RX success:** `rx_valid` with `rx_error`=0 and
  - probe: `rx_count`=24 and `rx_data[63:48]`=16'h0900; or
  - poll: `rx_count`=64 and `rx_data[63:61]`=3'b000.
- **On success:**
  - Retry counter resets to 0.
  - Probe → `connected`=1.
  - Poll → `pad_data`←`rx_data` and `pad_valid` pulses on the same cycle.
  - Next state: POLL_WAIT.
- **Failure:** `rx_valid` not meeting the success checks, or timeout counter reaching RESP_TIMEOUT-1 without `rx_valid`.
  - `err_count`+1 (saturating); retry+1.
  - If retry reaches MAX_RETRY: `connected`=0, retry=0, go to BACKOFF.
  - Otherwise reissue the same command type next cycle (PROBE_TX or POLL_TX).
- **`rx_valid` and timeout in the same cycle:** `rx_valid` wins.
- **POLL_WAIT:**
  - Exit to POLL_TX when the period counter reaches POLL_PERIOD-1.
  - If `enable`=0, go to IDLE.
  - The period counter runs in every state except IDLE and saturates at POLL_PERIOD-1. An overrun transaction therefore causes one immediate poll, not a burst.
- **BACKOFF:**
  - Wait POLL_PERIOD cycles (counter cleared on entry), then go to PROBE_TX.
  - `enable`=0 → IDLE.
- **`enable` deassertion** is only honoured in IDLE, POLL_WAIT, and BACKOFF. Active transactions always complete, including retries.
- **Pad disconnect:** `pad_data` holds its last value when `connected` falls.
- **Counter widths:** period and timeout counters are sized with $clog2 of their parameters.

Test Plan:
- Sim parameters: POLL_PERIOD=2000, RESP_TIMEOUT=300, MAX_RETRY=2.
1. Reset, `enable`=1, model returns 24-bit 0x090003 → one `tx_start` with `tx_cmd`=0x000000, `tx_len`=8; `connected`=1; next `tx_start` with `tx_cmd`=0x400300, `tx_len`=24.
2. Connected, `rumble`=1, model returns 64 bits 0x0080_8080_8080_0000 → `pad_data` equals that value; `pad_valid` pulses once; successive poll `tx_start` pulses exactly 2000 cycles apart.
3. Model silent on poll → `rx_arm` drops 300 cycles after `tx_done`; immediate re-poll; second timeout → `connected`=0, `err_count`=2; probe `tx_start` 2000 cycles later.
4. Poll response with `rx_count`=63, then `rx_data[63]`=1, then `rx_error`=1 → each is rejected; `pad_valid` never pulses; `err_count` increments per failure.
5. `tx_busy` held high 500 cycles at a poll slot → `tx_start` delayed until `tx_busy` falls; exactly one pulse.
6. Assert `reset` during WAIT_RX, and separately drop `enable` during WAIT_RX:
   - reset → all outputs 0 next cycle;
   - `enable` drop → transaction completes, then IDLE, with no further `tx_start`.

Source files
------------

// File: rtl/gc_poll_scheduler.sv
// GameCube controller link sequencer: probes for a pad, polls it on a fixed
// period with the rumble bit, validates replies and publishes button frames.
module gc_poll_scheduler #(
    parameter int POLL_PERIOD  = 1666666,
    parameter int RESP_TIMEOUT = 50000,
    parameter int MAX_RETRY    = 3
) (
    input  logic        clk100mhz,
    input  logic        reset,
    input  logic        enable,
    input  logic        rumble,
    output logic        tx_start,
    output logic [23:0] tx_cmd,
    output logic [4:0]  tx_len,
    input  logic        tx_busy,
    input  logic        tx_done,
    output logic        rx_arm,
    input  logic        rx_valid,
    input  logic [63:0] rx_data,
    input  logic [6:0]  rx_count,
    input  logic        rx_error,
    output logic [63:0] pad_data,
    output logic        pad_valid,
    output logic        connected,
    output logic [7:0]  err_count
);
    localparam int PW = $clog2(POLL_PERIOD);
    localparam int TW = $clog2(RESP_TIMEOUT);
    localparam int RW = $clog2(MAX_RETRY + 1);
    localparam logic [PW-1:0] PERIOD_LAST  = PW'(POLL_PERIOD - 1);
    localparam logic [PW-1:0] PERIOD_ONE   = PW'(1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(RESP_TIMEOUT - 1);
    localparam logic [TW-1:0] TIMEOUT_ONE  = TW'(1);
    localparam logic [RW-1:0] RETRY_LAST   = RW'(MAX_RETRY - 1);
    localparam logic [RW-1:0] RETRY_ONE    = RW'(1);

    typedef enum logic [2:0] {
        IDLE,
        PROBE_TX,
        POLL_WAIT,
        POLL_TX,
        WAIT_TXDONE,
        WAIT_RX,
        BACKOFF
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [PW-1:0] period_cnt;
    logic [TW-1:0] resp_cnt;
    logic [RW-1:0] retry_cnt;
    logic          is_poll;
    logic [23:0]   cmd_q;
    logic [4:0]    len_q;

    logic          issue;
    logic          resp_ok;
    logic          resp_fail;
    logic          resp_good;
    logic          last_retry;
    logic [23:0]   cmd_build;
    logic [4:0]    len_build;

    always_comb begin
        resp_good = 1'b0;
        if (!rx_error) begin
            if (is_poll) begin
                resp_good = (rx_count == 7'd64) && (rx_data[63:61] == 3'b000);
            end else begin
                resp_good = (rx_count == 7'd24) && (rx_data[63:48] == 16'h0900);
            end
        end
    end

    assign last_retry = (retry_cnt == RETRY_LAST);
    assign cmd_build  = (state == POLL_TX) ? {16'h4003, 7'b0, rumble} : 24'h000000;
    assign len_build  = (state == POLL_TX) ? 5'd24 : 5'd8;

    always_comb begin
        state_next = state;
        issue      = 1'b0;
        resp_ok    = 1'b0;
        resp_fail  = 1'b0;
        case (state)
            IDLE: begin
                if (enable) begin
                    state_next = connected ? POLL_WAIT : PROBE_TX;
                end
            end
            PROBE_TX, POLL_TX: begin
                if (!tx_busy) begin
                    issue      = 1'b1;
                    state_next = WAIT_TXDONE;
                end
            end
            WAIT_TXDONE: begin
                if (tx_done) begin
                    state_next = WAIT_RX;
                end
            end
            WAIT_RX: begin
                // A response arriving on the timeout cycle still counts as a response.
                if (rx_valid) begin
                    resp_ok   = resp_good;
                    resp_fail = !resp_good;
                end else if (resp_cnt == TIMEOUT_LAST) begin
                    resp_fail = 1'b1;
                end
                if (resp_ok) begin
                    state_next = POLL_WAIT;
                end else if (resp_fail) begin
                    if (last_retry) begin
                        state_next = BACKOFF;
                    end else begin
                        state_next = is_poll ? POLL_TX : PROBE_TX;
                    end
                end
            end
            POLL_WAIT: begin
                if (!enable) begin
                    state_next = IDLE;
                end else if (period_cnt == PERIOD_LAST) begin
                    state_next = POLL_TX;
                end
            end
            BACKOFF: begin
                if (!enable) begin
                    state_next = IDLE;
                end else if (period_cnt == PERIOD_LAST) begin
                    state_next = PROBE_TX;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // The command is visible on the start cycle and frozen in cmd_q afterwards.
    assign tx_start = issue;
    assign tx_cmd   = issue ? cmd_build : cmd_q;
    assign tx_len   = issue ? len_build : len_q;
    assign rx_arm   = (state == WAIT_RX);

    always_ff @(posedge clk100mhz) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk100mhz) begin
        if (reset) begin
            period_cnt <= '0;
            resp_cnt   <= '0;
            retry_cnt  <= '0;
            is_poll    <= 1'b0;
            cmd_q      <= '0;
            len_q      <= '0;
            pad_data   <= '0;
            pad_valid  <= 1'b0;
            connected  <= 1'b0;
            err_count  <= '0;
        end else begin
            pad_valid <= 1'b0;

            // The poll start cycle is cycle 0 of the new period, so poll starts
            // land exactly POLL_PERIOD cycles apart.
            if (issue && state == POLL_TX) begin
                period_cnt <= PERIOD_ONE;
            end else if (state_next == BACKOFF && state != BACKOFF) begin
                period_cnt <= '0;
            end else if (state != IDLE && period_cnt != PERIOD_LAST) begin
                period_cnt <= period_cnt + PERIOD_ONE;
            end

            if (state == WAIT_TXDONE && tx_done) begin
                resp_cnt <= '0;
            end else if (state == WAIT_RX && resp_cnt != TIMEOUT_LAST) begin
                resp_cnt <= resp_cnt + TIMEOUT_ONE;
            end

            if (issue) begin
                cmd_q   <= cmd_build;
                len_q   <= len_build;
                is_poll <= (state == POLL_TX);
            end

            if (resp_ok) begin
                retry_cnt <= '0;
                if (is_poll) begin
                    pad_data  <= rx_data;
                    pad_valid <= 1'b1;
                end else begin
                    connected <= 1'b1;
                end
            end

            if (resp_fail) begin
                if (err_count != 8'hFF) begin
                    err_count <= err_count + 8'd1;
                end
                if (last_retry) begin
                    connected <= 1'b0;
                    retry_cnt <= '0;
                end else begin
                    retry_cnt <= retry_cnt + RETRY_ONE;
                end
            end
        end
    end

endmodule

// File: tb/tb_gc_poll_scheduler.sv
// Bench for gc_poll_scheduler: a transmitter/receiver model answers from a
// response queue; a table of poll replies plus directed link sequences.
module tb_gc_poll_scheduler;
    localparam int P      = 2000;
    localparam int R      = 300;
    localparam int MR     = 2;
    localparam int TX_LAT = 5;
    localparam int RX_LAT = 10;
    localparam int W_TX   = 0;
    localparam int W_DONE = 1;
    localparam int W_RXV  = 2;
    localparam int W_CONN = 3;

    localparam logic [63:0] PROBE_RSP = {24'h090003, 40'h0};
    localparam logic [63:0] POLL_RSP  = 64'h0080_8080_8080_0000;

    typedef struct packed {
        logic [63:0] data;
        logic [6:0]  count;
        logic        err;
        logic        pad;
    } vec_t;

    logic        clk100mhz;
    logic        reset;
    logic        enable;
    logic        rumble;
    logic        tx_start;
    logic [23:0] tx_cmd;
    logic [4:0]  tx_len;
    logic        tx_busy;
    logic        tx_done;
    logic        rx_arm;
    logic        rx_valid;
    logic [63:0] rx_data;
    logic [6:0]  rx_count;
    logic        rx_error;
    logic [63:0] pad_data;
    logic        pad_valid;
    logic        connected;
    logic [7:0]  err_count;

    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;
    int tx_count = 0;
    int last_tx_cyc = 0;
    int pv_count = 0;

    vec_t        rsp_q[$];
    logic [63:0] exp_q[$];
    vec_t        tbl[8];

    gc_poll_scheduler #(
        .POLL_PERIOD(P),
        .RESP_TIMEOUT(R),
        .MAX_RETRY(MR)
    ) dut (
        .clk100mhz(clk100mhz),
        .reset(reset),
        .enable(enable),
        .rumble(rumble),
        .tx_start(tx_start),
        .tx_cmd(tx_cmd),
        .tx_len(tx_len),
        .tx_busy(tx_busy),
        .tx_done(tx_done),
        .rx_arm(rx_arm),
        .rx_valid(rx_valid),
        .rx_data(rx_data),
        .rx_count(rx_count),
        .rx_error(rx_error),
        .pad_data(pad_data),
        .pad_valid(pad_valid),
        .connected(connected),
        .err_count(err_count)
    );

    // Clock and cycle index
    initial begin
        clk100mhz = 1'b0;
        forever #5 clk100mhz = ~clk100mhz;
    end

    always @(posedge clk100mhz) cyc <= cyc + 1;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation still running at cycle %0d, required to finish earlier", cyc);
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic drive_edge();
        @(posedge clk100mhz);
        #1;
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk100mhz);
    endtask

    task automatic wait_for(input int which, input int budget, input string name, output int at);
        logic hit;
        at = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk100mhz);
            case (which)
                W_TX:    hit = tx_start;
                W_DONE:  hit = tx_done;
                W_RXV:   hit = rx_valid;
                default: hit = connected;
            endcase
            if (hit === 1'b1) begin
                at = cyc;
                break;
            end
        end
        n_checks++;
        if (at < 0) begin
            n_fail++;
            $display("FAIL %s: no event within %0d cycles, required one", name, budget);
        end
    endtask

    task automatic push_rsp(input logic [63:0] d, input logic [6:0] c, input logic e, input logic pad);
        vec_t v;
        v.data  = d;
        v.count = c;
        v.err   = e;
        v.pad   = pad;
        rsp_q.push_back(v);
        if (pad) exp_q.push_back(d);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_tx_start"}, 64'(tx_start), 64'd0);
        check({tag, "_tx_cmd"}, 64'(tx_cmd), 64'd0);
        check({tag, "_tx_len"}, 64'(tx_len), 64'd0);
        check({tag, "_rx_arm"}, 64'(rx_arm), 64'd0);
        check({tag, "_pad_data"}, pad_data, 64'd0);
        check({tag, "_pad_valid"}, 64'(pad_valid), 64'd0);
        check({tag, "_connected"}, 64'(connected), 64'd0);
        check({tag, "_err_count"}, 64'(err_count), 64'd0);
    endtask

    // Transmitter + receiver model: each tx_start consumes one queued reply
    // (empty queue = silent pad).
    initial begin : pad_model
        vec_t r;
        logic have;
        tx_done  = 1'b0;
        rx_valid = 1'b0;
        rx_data  = '0;
        rx_count = '0;
        rx_error = 1'b0;
        r        = '0;
        forever begin
            @(negedge clk100mhz);
            if (tx_start === 1'b1) begin
                have = (rsp_q.size() != 0);
                if (have) r = rsp_q.pop_front();
                repeat (TX_LAT) @(posedge clk100mhz);
                #1 tx_done = 1'b1;
                @(posedge clk100mhz);
                #1 tx_done = 1'b0;
                if (have) begin
                    repeat (RX_LAT) @(posedge clk100mhz);
                    #1;
                    rx_valid = 1'b1;
                    rx_data  = r.data;
                    rx_count = r.count;
                    rx_error = r.err;
                    @(posedge clk100mhz);
                    #1 rx_valid = 1'b0;
                end
            end
        end
    end

    // Scoreboard: every pad_valid must match the next expected frame.
    always @(negedge clk100mhz) begin
        if (tx_start === 1'b1) begin
            tx_count++;
            last_tx_cyc = cyc;
        end
        if (pad_valid === 1'b1) begin
            pv_count++;
            if (exp_q.size() == 0) check("pad_valid_spurious", 64'(pad_valid), 64'd0);
            else check("pad_data_sb", pad_data, exp_q.pop_front());
        end
    end

    initial begin : main
        int t;
        int t0;
        int t1;
        int t2;
        int d;
        int fall;
        int n0;
        int drop;
        int err_exp;
        int pv_exp;
        logic [63:0] pad_exp;

        tbl[0] = '{data: 64'h0080_8080_8080_0000, count: 7'd63, err: 1'b0, pad: 1'b0};
        tbl[1] = '{data: 64'h1234_5678_9ABC_DEF0, count: 7'd64, err: 1'b0, pad: 1'b1};
        tbl[2] = '{data: 64'h8080_8080_8080_0000, count: 7'd64, err: 1'b0, pad: 1'b0};
        tbl[3] = '{data: 64'h0F0F_0000_1111_2222, count: 7'd64, err: 1'b0, pad: 1'b1};
        tbl[4] = '{data: 64'h0080_8080_8080_0000, count: 7'd64, err: 1'b1, pad: 1'b0};
        tbl[5] = '{data: 64'h1FFF_FFFF_FFFF_FFFF, count: 7'd64, err: 1'b0, pad: 1'b1};
        tbl[6] = '{data: 64'h2000_0000_0000_0001, count: 7'd64, err: 1'b0, pad: 1'b0};
        tbl[7] = '{data: 64'h0000_0000_0000_0001, count: 7'd64, err: 1'b0, pad: 1'b1};

        reset   = 1'b1;
        enable  = 1'b0;
        rumble  = 1'b0;
        tx_busy = 1'b0;
        repeat (3) @(posedge clk100mhz);
        #1 reset = 1'b0;
        @(negedge clk100mhz);
        check_all_zero("reset");

        // Probe, connect, first poll without rumble
        push_rsp(PROBE_RSP, 7'd24, 1'b0, 1'b0);
        repeat (3) push_rsp(POLL_RSP, 7'd64, 1'b0, 1'b1);
        drive_edge();
        enable = 1'b1;
        wait_for(W_TX, 50, "probe_start", t);
        check("probe_cmd", 64'(tx_cmd), 64'h000000);
        check("probe_len", 64'(tx_len), 64'd8);
        wait_for(W_CONN, 100, "probe_connect", t);
        check("connected_after_probe", 64'(connected), 64'd1);
        wait_for(W_TX, 2500, "poll1_start", t0);
        check("poll1_cmd", 64'(tx_cmd), 64'h400300);
        check("poll1_len", 64'(tx_len), 64'd24);

        // Rumble and poll period
        rumble = 1'b1;
        wait_for(W_TX, 2500, "poll2_start", t1);
        check("poll2_cmd", 64'(tx_cmd), 64'h400301);
        check("poll_spacing_1", 64'(t1 - t0), 64'(P));
        wait_for(W_TX, 2500, "poll3_start", t2);
        check("poll_spacing_2", 64'(t2 - t1), 64'(P));
        step(40);
        check("pad_valid_count_3", 64'(pv_count), 64'd3);
        check("pad_data_poll", pad_data, POLL_RSP);

        // Silent pad: timeout, immediate re-poll, second timeout disconnects
        wait_for(W_TX, 2500, "poll4_start", t);
        check("poll_spacing_3", 64'(t - t2), 64'(P));
        wait_for(W_DONE, 50, "poll4_done", d);
        step(R);
        check("rx_arm_last_cycle", 64'(rx_arm), 64'd1);
        step(1);
        check("rx_arm_dropped", 64'(rx_arm), 64'd0);
        check("repoll_immediate", 64'(tx_start), 64'd1);
        check("err_after_timeout1", 64'(err_count), 64'd1);
        check("still_connected", 64'(connected), 64'd1);
        wait_for(W_DONE, 50, "repoll_done", d);
        step(R + 1);
        check("rx_arm_dropped_2", 64'(rx_arm), 64'd0);
        check("disconnected", 64'(connected), 64'd0);
        check("err_after_timeout2", 64'(err_count), 64'd2);
        check("pad_data_held", pad_data, POLL_RSP);
        fall = cyc;
        push_rsp(PROBE_RSP, 7'd24, 1'b0, 1'b0);
        wait_for(W_TX, P + 100, "backoff_probe", t);
        check("backoff_delay", 64'(t - fall), 64'(P));
        check("backoff_probe_cmd", 64'(tx_cmd), 64'h000000);
        check("backoff_probe_len", 64'(tx_len), 64'd8);
        wait_for(W_CONN, 100, "reconnect", t);
        check("err_after_reconnect", 64'(err_count), 64'd2);

        // Table of poll replies: rejects interleaved with accepts
        err_exp = 2;
        pv_exp  = 3;
        pad_exp = POLL_RSP;
        for (int i = 0; i < 8; i++) push_rsp(tbl[i].data, tbl[i].count, tbl[i].err, tbl[i].pad);
        for (int i = 0; i < 8; i++) begin
            wait_for(W_RXV, 2500, "table_rx", t);
            step(2);
            if (tbl[i].pad) begin
                pv_exp++;
                pad_exp = tbl[i].data;
            end else begin
                err_exp++;
            end
            check("table_err_count", 64'(err_count), 64'(err_exp));
            check("table_pad_valid_count", 64'(pv_count), 64'(pv_exp));
            check("table_pad_data", pad_data, pad_exp);
            check("table_connected", 64'(connected), 64'd1);
        end

        // tx_busy held across a poll slot
        push_rsp(64'h0000_1111_2222_3333, 7'd64, 1'b0, 1'b1);
        drive_edge();
        tx_busy = 1'b1;
        n0 = tx_count;
        t0 = last_tx_cyc;
        while (cyc < t0 + P + 500) @(negedge clk100mhz);
        check("busy_no_start", 64'(tx_count), 64'(n0));
        drive_edge();
        tx_busy = 1'b0;
        drop = cyc;
        wait_for(W_TX, 5, "busy_release_start", t);
        check("busy_release_cycle", 64'(t), 64'(drop));
        check("busy_release_cmd", 64'(tx_cmd), 64'h400301);
        step(40);
        check("busy_single_start", 64'(tx_count), 64'(n0 + 1));
        pv_exp++;
        check("busy_pad_valid_count", 64'(pv_count), 64'(pv_exp));

        // Reset during WAIT_RX
        push_rsp(64'h0011_0000_0000_0000, 7'd64, 1'b0, 1'b0);
        wait_for(W_TX, P + 100, "pre_reset_poll", t1);
        check("post_overrun_spacing", 64'(t1 - t), 64'(P));
        wait_for(W_DONE, 50, "pre_reset_done", d);
        step(3);
        check("rx_arm_before_reset", 64'(rx_arm), 64'd1);
        drive_edge();
        enable = 1'b0;
        reset  = 1'b1;
        drive_edge();
        reset = 1'b0;
        @(negedge clk100mhz);
        check_all_zero("midreset");
        n0 = tx_count;
        step(40);
        check("midreset_no_pad", 64'(pv_count), 64'(pv_exp));
        check("midreset_no_start", 64'(tx_count), 64'(n0));

        // enable dropped during WAIT_RX: transaction completes, then idle
        push_rsp(PROBE_RSP, 7'd24, 1'b0, 1'b0);
        push_rsp(64'h0011_2233_4455_6677, 7'd64, 1'b0, 1'b1);
        drive_edge();
        enable = 1'b1;
        wait_for(W_CONN, 200, "reenable_connect", t);
        wait_for(W_TX, P + 100, "last_poll_start", t);
        check("last_poll_cmd", 64'(tx_cmd), 64'h400301);
        wait_for(W_DONE, 50, "last_poll_done", d);
        drive_edge();
        enable = 1'b0;
        step(30);
        pv_exp++;
        check("disable_completes_pad", 64'(pv_count), 64'(pv_exp));
        check("disable_pad_data", pad_data, 64'h0011_2233_4455_6677);
        n0 = tx_count;
        step(P + 500);
        check("disable_no_start", 64'(tx_count), 64'(n0));
        check("disable_rx_arm", 64'(rx_arm), 64'd0);
        check("disable_connected", 64'(connected), 64'd1);

        check("exp_q_drained", 64'(exp_q.size()), 64'd0);
        check("rsp_q_drained", 64'(rsp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
